// File: rtl/npc_pkg.sv
// Shared core constants and the fetch-buffer entry type.
// The entry type fixes the PC and instruction widths for every instance that uses it.
package npc_pkg;

    localparam int unsigned    XLEN     = 64;
    localparam int unsigned    INST_W   = 32;
    localparam logic [XLEN-1:0] RESET_PC = 64'h0000_0000_8000_0000;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [INST_W-1:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/ifu_fifo.sv
// Synchronous FIFO with a flush port, generic over the element type.
// Holds decoded-ready fetch entries, and also serves as the in-flight PC shadow queue.
module ifu_fifo
    import npc_pkg::*;
#(
    parameter type         T     = fetch_entry_t,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  T                       push_data,
    input  logic                   pop,
    output T                       head,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (push)           wr_ptr_d = wr_ptr_q + PW'(1);
            if (pop && !empty)  rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/ifu_fetch_buffer.sv
// Instruction-fetch unit: owns the fetch PC, issues in-order imem requests and buffers
// returned instructions for the decoder. Optional IFU_PERF_EN adds pop/stall counters.
module ifu_fetch_buffer
    import npc_pkg::fetch_entry_t;
#(
    parameter int unsigned      XLEN     = npc_pkg::XLEN,
    parameter int unsigned      INST_W   = npc_pkg::INST_W,
    parameter logic [XLEN-1:0]  RESET_PC = npc_pkg::RESET_PC,
    parameter int unsigned      DEPTH    = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [XLEN-1:0]   imem_req_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst_data,
    output logic [XLEN-1:0]   inst_pc,
    input  logic              redirect_valid,
    input  logic [XLEN-1:0]   redirect_pc,
    input  logic              halt,
    output logic              halted
`ifdef IFU_PERF_EN
    ,
    output logic [63:0]       perf_fetched,
    output logic [63:0]       perf_stall
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   drop_q, drop_d;
    logic            halted_q, halted_d;

    logic            req_fire, rsp_keep, inst_pop;
    logic [PW-1:0]   fifo_cnt;
    logic            fifo_empty;
    fetch_entry_t    fifo_head;
    logic [XLEN-1:0] pcq_head;
    logic            pcq_empty;
    logic [PW-1:0]   pcq_cnt_unused;

    // Credit counts buffered entries plus everything still owed by imem, including drops.
    assign imem_req_valid = !rst && !halted_q && !halt && !redirect_valid
                            && ((32'(fifo_cnt) + 32'(outstanding_q)) < DEPTH);
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign rsp_keep   = imem_rsp_valid && (drop_q == '0) && !redirect_valid && !pcq_empty;
    assign inst_valid = !fifo_empty && !redirect_valid;
    assign inst_pop   = inst_valid && inst_ready;
    assign inst_data  = fifo_head.inst;
    assign inst_pc    = fifo_head.pc;
    assign halted     = halted_q;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(imem_rsp_valid);
        drop_d        = drop_q;
        halted_d      = halted_q || halt;
        if (redirect_valid) begin
            // A response arriving this cycle is already discarded, so it is not owed a drop.
            fetch_pc_d = redirect_pc;
            drop_d     = outstanding_q - CW'(imem_rsp_valid);
        end else begin
            if (req_fire)                         fetch_pc_d = fetch_pc_q + XLEN'(4);
            if (imem_rsp_valid && drop_q != '0)   drop_d     = drop_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            drop_q        <= '0;
            halted_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            halted_q      <= halted_d;
        end
    end

    // PCs of requests whose responses will still be kept, oldest first.
    ifu_fifo #(
        .T     (logic [XLEN-1:0]),
        .DEPTH (DEPTH)
    ) u_pc_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc_q),
        .pop       (rsp_keep),
        .head      (pcq_head),
        .empty     (pcq_empty),
        .count     (pcq_cnt_unused)
    );

    ifu_fifo #(
        .T     (fetch_entry_t),
        .DEPTH (DEPTH)
    ) u_inst_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data (fetch_entry_t'{pc: pcq_head, inst: imem_rsp_data}),
        .pop       (inst_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_cnt)
    );

`ifdef IFU_PERF_EN
    logic [63:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (inst_pop && !(&perf_fetched_q))                 perf_fetched_q <= perf_fetched_q + 64'd1;
            if (!inst_valid && !halted_q && !(&perf_stall_q))  perf_stall_q   <= perf_stall_q + 64'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule
